ysyx_23060025_wbu: RTL and testbench
====================================

// Module: ysyx_23060025_wbu
// PURPOSE
//  Writeback stage directly upstream of the register file. Accepts one retiring instruction per handshake from EXU/LSU,
//  waits for load data when needed, extracts/sign-extends load bytes, and drives the register-file write port
//  (wdata/rd/regWrite) as a registered single-cycle pulse. Also emits a commit pulse per retired instruction.
// PARAMETERS
//  DATA_WIDTH  32  datapath width; only 32 is supported
//  REG_NUM     16  architectural registers (RV32E); rd >= REG_NUM is illegal
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-low reset
//  in_valid     in   1   upstream holds a retiring instruction
//  in_ready     out  1   WBU can accept this cycle
//  in_wen       in   1   instruction writes rd
//  in_rd        in   5   destination register index
//  in_sel       in   2   result source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR
//  in_res       in   32  ALU or CSR result (by in_sel)
//  in_pc        in   32  instruction PC
//  in_funct3    in   3   load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  in_addr_lo   in   2   load address bits [1:0]
//  mem_rvalid   in   1   load data return strobe
//  mem_rdata    in   32  load data word (aligned)
//  wdata        out  32  to register file
//  rd           out  5   to register file
//  regWrite     out  1   to register file; one-cycle pulse
//  commit_valid out  1   one-cycle pulse per retired instruction
//  commit_pc    out  32  PC of retired instruction
//  ill_rd       out  1   one-cycle pulse: retired with in_wen=1 and rd >= REG_NUM
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; regWrite, commit_valid, ill_rd = 0; wdata, rd, commit_pc = 0. Pending load dropped.
//  - States: IDLE, WAIT_LOAD. in_ready = (state==IDLE). Handshake fires when in_valid && in_ready.
//  - IDLE, fire, in_sel!=LOAD: outputs registered; regWrite/commit_valid asserted cycle N+1, exactly 1 cycle. Stay IDLE:
//    back-to-back accepts give one writeback per cycle.
//  - IDLE, fire, in_sel==LOAD: latch rd/wen/funct3/addr_lo/pc; go WAIT_LOAD; no output pulse.
//  - WAIT_LOAD: in_ready=0; on mem_rvalid, extract data, pulses on next cycle, return IDLE. Waits indefinitely otherwise.
//  - mem_rvalid while IDLE: ignored, no state change.
//  - PC+4 result: in_pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//  - Load extraction: byte lane = addr_lo; half lane = addr_lo[1] (addr_lo[0] ignored; alignment enforced upstream).
//    LB/LH sign-extend; LBU/LHU zero-extend; LW whole word; other funct3 -> whole word.
//  - regWrite = wen && rd!=0 && rd<REG_NUM. rd==0: commit_valid pulses, regWrite stays 0.
//    rd>=REG_NUM with wen: no write, ill_rd pulses with commit_valid.
//  - wdata/rd hold their last value when regWrite=0.
// CONFIGURATION
//  WBU_BYPASS_EN defined: extra outputs fwd_valid(1), fwd_rd(5), fwd_data(32) = registered regWrite/rd/wdata, exposed
//    so decode can bypass the in-flight write in the cycle it lands in the register file.
//  Not defined: ports absent; decode stalls on RAW against WBU. Core WBU behaviour identical either way.
// STRUCTURE
//  Package ysyx_23060025_wbu_pkg: in_sel encodings (SEL_ALU/LOAD/PC4/CSR), load funct3 constants, state enum.
//  Sub-module ysyx_23060025_load_ext: combinational (funct3, addr_lo, rdata) -> 32-bit extended result.
//  Top: FSM, latch registers, output registers.
// TESTING
//  1 ALU: in_sel=0, rd=5, res=0x1234 accepted cycle N -> cycle N+1 regWrite=1, rd=5, wdata=0x1234; cycle N+2 regWrite=0.
//  2 LB: addr_lo=3, rdata=0x80FF_0000 after 3 wait cycles -> in_ready=0 while waiting; wdata=0xFFFFFF80 one cycle after rvalid.
//    LHU addr_lo=2 same rdata -> 0x000080FF.
//  3 Back-to-back: ALU ops rd=1,2,3 on consecutive cycles -> three consecutive regWrite pulses in order.
//  4 Boundaries: rd=0 -> commit_valid=1, regWrite=0; rd=17 wen=1 -> ill_rd=1, regWrite=0; PC4 pc=0xFFFFFFFC -> wdata=0.
//  5 Reset in WAIT_LOAD: reset=0 one cycle then mem_rvalid -> no regWrite, in_ready=1, all outputs 0.
//  6 Spurious mem_rvalid in IDLE -> no pulse, state unchanged; with WBU_BYPASS_EN, fwd_* mirror test 1's write.

Source files
------------

// File: rtl/ysyx_23060025_wbu_pkg.sv
// Shared encodings for the writeback stage: result sources, load types, FSM states.
package ysyx_23060025_wbu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_N  = 16;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned F3_W   = 3;

  // Result source select
  localparam logic [SEL_W-1:0] SEL_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_LOAD = 2'd1;
  localparam logic [SEL_W-1:0] SEL_PC4  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_CSR  = 2'd3;

  // Load funct3 types
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060025_load_ext.sv
// Load data lane select and sign/zero extension (purely combinational).
module ysyx_23060025_load_ext
  import ysyx_23060025_wbu_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half, then extend according to load type
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    result_c  = rdata;
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    // Halfword alignment is guaranteed upstream, so only addr_lo[1] matters
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result_c = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   result_c = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  result_c = {24'h000000, byte_lane};
      F3_LHU:  result_c = {16'h0000, half_lane};
      F3_LW:   result_c = rdata;
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_wbu.sv
// Writeback stage: accepts retiring instructions, waits for load data, drives the
// register-file write port and a commit pulse. Optional macro WBU_BYPASS_EN exposes
// the in-flight register write (fwd_*) for decode bypassing.
module ysyx_23060025_wbu
  import ysyx_23060025_wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned REG_NUM    = REG_N
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [RD_W-1:0]       in_rd,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_WIDTH-1:0] in_res,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [F3_W-1:0]       in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [RD_W-1:0]       rd,
  output logic                  regWrite,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
`ifdef WBU_BYPASS_EN
  output logic                  fwd_valid,
  output logic [RD_W-1:0]       fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic                  ill_rd
);

  wbu_state_e            state_q, state_d;
  logic                  ld_wen_q, ld_wen_d;
  logic [RD_W-1:0]       ld_rd_q, ld_rd_d;
  logic [F3_W-1:0]       ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;
  logic [DATA_WIDTH-1:0] ld_pc_q, ld_pc_d;

  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]       rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [DATA_WIDTH-1:0] commit_pc_q, commit_pc_d;
  logic                  ill_rd_q, ill_rd_d;

  logic [DATA_WIDTH-1:0] ld_data_c;

  logic                  ret_en, ret_wen, rd_ok;
  logic [RD_W-1:0]       ret_rd;
  logic [DATA_WIDTH-1:0] ret_val, ret_pc;

  ysyx_23060025_load_ext u_load_ext (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .rdata   (mem_rdata),
    .result_c(ld_data_c)
  );

  // Next-state, load-context capture and registered writeback/commit outputs
  always_comb begin
    state_d        = state_q;
    ld_wen_d       = ld_wen_q;
    ld_rd_d        = ld_rd_q;
    ld_f3_d        = ld_f3_q;
    ld_lo_d        = ld_lo_q;
    ld_pc_d        = ld_pc_q;
    ret_en         = 1'b0;
    ret_wen        = 1'b0;
    ret_rd         = '0;
    ret_val        = '0;
    ret_pc         = '0;
    rd_ok          = 1'b0;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    reg_write_d    = 1'b0;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    ill_rd_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_sel == SEL_LOAD) begin
            ld_wen_d = in_wen;
            ld_rd_d  = in_rd;
            ld_f3_d  = in_funct3;
            ld_lo_d  = in_addr_lo;
            ld_pc_d  = in_pc;
            state_d  = ST_WAIT_LOAD;
          end else begin
            ret_en  = 1'b1;
            ret_wen = in_wen;
            ret_rd  = in_rd;
            ret_pc  = in_pc;
            ret_val = (in_sel == SEL_PC4) ? (in_pc + DATA_WIDTH'(4)) : in_res;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (mem_rvalid) begin
          ret_en  = 1'b1;
          ret_wen = ld_wen_q;
          ret_rd  = ld_rd_q;
          ret_pc  = ld_pc_q;
          ret_val = ld_data_c;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_ok = 32'(ret_rd) < REG_NUM;
    if (ret_en) begin
      commit_valid_d = 1'b1;
      commit_pc_d    = ret_pc;
      ill_rd_d       = ret_wen && !rd_ok;
      if (ret_wen && rd_ok && (ret_rd != '0)) begin
        reg_write_d = 1'b1;
        wdata_d     = ret_val;
        rd_d        = ret_rd;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ld_wen_q       <= 1'b0;
      ld_rd_q        <= '0;
      ld_f3_q        <= '0;
      ld_lo_q        <= '0;
      ld_pc_q        <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      ill_rd_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ld_wen_q       <= ld_wen_d;
      ld_rd_q        <= ld_rd_d;
      ld_f3_q        <= ld_f3_d;
      ld_lo_q        <= ld_lo_d;
      ld_pc_q        <= ld_pc_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      ill_rd_q       <= ill_rd_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign wdata        = wdata_q;
  assign rd           = rd_q;
  assign regWrite     = reg_write_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign ill_rd       = ill_rd_q;

`ifdef WBU_BYPASS_EN
  // The write landing in the register file this cycle, visible to decode
  assign fwd_valid = reg_write_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_23060025_wbu.sv
// Self-checking bench for ysyx_23060025_wbu: directed tables, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_ysyx_23060025_wbu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_wen, mem_rvalid;
  logic [4:0]  in_rd, rd;
  logic [1:0]  in_sel, in_addr_lo;
  logic [2:0]  in_funct3;
  logic [31:0] in_res, in_pc, mem_rdata, wdata, commit_pc;
  logic        regWrite, commit_valid, ill_rd;
`ifdef WBU_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  ysyx_23060025_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
    .in_sel(in_sel), .in_res(in_res), .in_pc(in_pc), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wdata(wdata), .rd(rd), .regWrite(regWrite), .commit_valid(commit_valid),
    .commit_pc(commit_pc),
`ifdef WBU_BYPASS_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .ill_rd(ill_rd)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: at most one outstanding load, plus expected output values
  logic        pend;
  logic        p_wen;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [1:0]  p_lo;
  logic [31:0] p_pc;
  logic        e_rw, e_cv, e_ill;
  logic [31:0] e_wd, e_pc;
  logic [4:0]  e_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (32'(lo) * 8)) % 32'd256;
    h = (w >> (32'(lo[1]) * 16)) % 32'd65536;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_retire(input logic wen, input logic [4:0] r, input logic [31:0] v,
                              input logic [31:0] pc);
    e_cv  = 1'b1;
    e_pc  = pc;
    e_ill = wen && (r >= 5'd16);
    if (wen && r != 5'd0 && r < 5'd16) begin
      e_rw = 1'b1;
      e_wd = v;
      e_rd = r;
    end
  endtask

  task automatic check_outputs();
    chk("regWrite", 32'(regWrite), 32'(e_rw));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    chk("ill_rd", 32'(ill_rd), 32'(e_ill));
    chk("wdata", wdata, e_wd);
    chk("rd", 32'(rd), 32'(e_rd));
    if (e_cv) chk("commit_pc", commit_pc, e_pc);
`ifdef WBU_BYPASS_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(e_rw));
    chk("fwd_rd", 32'(fwd_rd), 32'(e_rd));
    chk("fwd_data", fwd_data, e_wd);
`endif
  endtask

  // One clock: drive inputs, predict, advance, compare
  task automatic cycle(input logic v, input logic wen, input logic [4:0] r, input logic [1:0] sel,
                       input logic [31:0] res, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [1:0] lo, input logic rv, input logic [31:0] rdata);
    in_valid = v; in_wen = wen; in_rd = r; in_sel = sel; in_res = res; in_pc = pc;
    in_funct3 = f3; in_addr_lo = lo; mem_rvalid = rv; mem_rdata = rdata;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!pend));
    e_rw = 1'b0; e_cv = 1'b0; e_ill = 1'b0;
    if (!pend) begin
      if (v) begin
        if (sel == 2'd1) begin
          pend = 1'b1; p_wen = wen; p_rd = r; p_f3 = f3; p_lo = lo; p_pc = pc;
        end else begin
          model_retire(wen, r, (sel == 2'd2) ? pc + 32'd4 : res, pc);
        end
      end
    end else if (rv) begin
      model_retire(p_wen, p_rd, ref_load(p_f3, p_lo, rdata), p_pc);
      pend = 1'b0;
    end
    @(posedge clock); #1;
    check_outputs();
  endtask

  task automatic idle(input logic rv);
    cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0, rv, 32'hA5A5_5A5A);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_wen = 1'b0; in_rd = '0; in_sel = '0; in_res = '0; in_pc = '0;
    in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    pend = 1'b0; e_rw = 1'b0; e_cv = 1'b0; e_ill = 1'b0; e_wd = '0; e_rd = '0; e_pc = '0;
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs();
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        wen;
    logic [4:0]  r;
    logic [31:0] res;
    logic [31:0] pc;
    logic        exp_rw;
    logic        exp_ill;
    logic [31:0] exp_wd;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  alu_vec_t alu_tbl[8];
  ld_vec_t  ld_tbl[10];

  initial begin
    alu_tbl[0] = '{2'd0, 1'b1, 5'd5,  32'h0000_1234, 32'h100, 1'b1, 1'b0, 32'h0000_1234};
    alu_tbl[1] = '{2'd0, 1'b1, 5'd0,  32'h0000_7777, 32'h104, 1'b0, 1'b0, 32'h0};
    alu_tbl[2] = '{2'd0, 1'b1, 5'd17, 32'h0000_8888, 32'h108, 1'b0, 1'b1, 32'h0};
    alu_tbl[3] = '{2'd2, 1'b1, 5'd3,  32'h0000_9999, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0};
    alu_tbl[4] = '{2'd3, 1'b1, 5'd15, 32'hDEAD_BEEF, 32'h110, 1'b1, 1'b0, 32'hDEAD_BEEF};
    alu_tbl[5] = '{2'd0, 1'b1, 5'd16, 32'h0000_0001, 32'h114, 1'b0, 1'b1, 32'h0};
    alu_tbl[6] = '{2'd0, 1'b0, 5'd4,  32'h0000_0002, 32'h118, 1'b0, 1'b0, 32'h0};
    alu_tbl[7] = '{2'd2, 1'b1, 5'd1,  32'h0000_0003, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0004};

    ld_tbl[0] = '{3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
    ld_tbl[1] = '{3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
    ld_tbl[2] = '{3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
    ld_tbl[3] = '{3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080};
    ld_tbl[4] = '{3'b010, 2'd0, 32'h80FF_0000, 32'h80FF_0000};
    ld_tbl[5] = '{3'b000, 2'd2, 32'h80FF_0000, 32'hFFFF_FFFF};
    ld_tbl[6] = '{3'b100, 2'd1, 32'h1234_5678, 32'h0000_0056};
    ld_tbl[7] = '{3'b001, 2'd1, 32'h1234_5678, 32'h0000_5678};
    ld_tbl[8] = '{3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001};
    ld_tbl[9] = '{3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};

    do_reset();

    // Single-cycle result sources and rd boundaries
    foreach (alu_tbl[i]) begin
      cycle(1'b1, alu_tbl[i].wen, alu_tbl[i].r, alu_tbl[i].sel, alu_tbl[i].res, alu_tbl[i].pc,
            3'd0, 2'd0, 1'b0, 32'd0);
      chk("tbl_regWrite", 32'(regWrite), 32'(alu_tbl[i].exp_rw));
      chk("tbl_ill_rd", 32'(ill_rd), 32'(alu_tbl[i].exp_ill));
      chk("tbl_commit", 32'(commit_valid), 32'd1);
      if (alu_tbl[i].exp_rw) chk("tbl_wdata", wdata, alu_tbl[i].exp_wd);
      idle(1'b0);
      chk("tbl_pulse_end", 32'(regWrite), 32'd0);
    end

    // Loads with three wait cycles before data returns
    foreach (ld_tbl[i]) begin
      cycle(1'b1, 1'b1, 5'd7, 2'd1, 32'hBAD0_BAD0, 32'h200 + 32'(i) * 4, ld_tbl[i].f3,
            ld_tbl[i].lo, 1'b0, 32'd0);
      chk("ld_no_pulse", 32'(commit_valid), 32'd0);
      for (int w = 0; w < 3; w++) begin
        idle(1'b0);
        chk("ld_wait_ready", 32'(in_ready), 32'd0);
      end
      cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0, 1'b1, ld_tbl[i].rdata);
      chk("ld_regWrite", 32'(regWrite), 32'd1);
      chk("ld_wdata", wdata, ld_tbl[i].exp);
      idle(1'b0);
    end

    // Back-to-back ALU writes: one writeback per cycle, in order
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 1'b1, 5'(k), 2'd0, 32'(k) * 32'h11, 32'h300, 3'd0, 2'd0, 1'b0, 32'd0);
      chk("b2b_rd", 32'(rd), 32'(k));
      chk("b2b_regWrite", 32'(regWrite), 32'd1);
    end
    idle(1'b0);

    // Reset while waiting for load data drops the load
    cycle(1'b1, 1'b1, 5'd9, 2'd1, 32'd0, 32'h400, 3'b010, 2'd0, 1'b0, 32'd0);
    idle(1'b0);
    do_reset();
    idle(1'b1);
    chk("rst_drop_regWrite", 32'(regWrite), 32'd0);
    chk("rst_drop_wdata", wdata, 32'd0);

    // Spurious data strobe in IDLE after a write
    cycle(1'b1, 1'b1, 5'd5, 2'd0, 32'h0000_1234, 32'h500, 3'd0, 2'd0, 1'b0, 32'd0);
    idle(1'b1);
    chk("spur_regWrite", 32'(regWrite), 32'd0);
    chk("spur_ready", 32'(in_ready), 32'd1);
    chk("spur_hold_wdata", wdata, 32'h0000_1234);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 5))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
        3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b111;
      endcase
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 19)), 2'($urandom_range(0, 3)), $urandom, $urandom,
            f3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0), $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
